// File: rtl/mant_align_pipe.sv
// Two-stage operand alignment for a floating-point adder: unpacks both operands,
// forms signed left-justified significands and right-shifts the one with the smaller exponent.
module mant_align_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int OUT_W = 2*MAN_W + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_a,
  output logic [OUT_W-1:0]     out_b,
  output logic [EXP_W-1:0]     out_exp,
  output logic                 out_sticky
);

  localparam int SIG_W = MAN_W + 2;
  localparam int PAD_W = MAN_W + 1;
  localparam int OP_W  = 1 + EXP_W + MAN_W;
  localparam logic [OUT_W-1:0] ONES = '1;

  // ---------------------------------------------------------------- handshake
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s2_load;
  logic w_s1_adv;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_adv  = w_s2_load || !r_s1_valid;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;

  // ------------------------------------------------------- stage 1: unpack
  logic [EXP_W-1:0] w_exp_a, w_exp_b;
  logic [EXP_W-1:0] w_eff_a, w_eff_b;
  logic [SIG_W-1:0] w_mag_a, w_mag_b;
  logic [SIG_W-1:0] w_sig_a, w_sig_b;
  logic             w_neg_a, w_neg_b;
  logic             w_b_small;

  // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    w_exp_a   = op_a[OP_W-2 -: EXP_W];
    w_exp_b   = op_b[OP_W-2 -: EXP_W];
    w_eff_a   = (w_exp_a == '0) ? EXP_W'(1) : w_exp_a;
    w_eff_b   = (w_exp_b == '0) ? EXP_W'(1) : w_exp_b;
    w_mag_a   = {1'b0, (w_exp_a != '0), op_a[MAN_W-1:0]};
    w_mag_b   = {1'b0, (w_exp_b != '0), op_b[MAN_W-1:0]};
    w_neg_a   = op_a[OP_W-1];
    w_neg_b   = op_b[OP_W-1] ^ sub;
    w_sig_a   = w_neg_a ? -w_mag_a : w_mag_a;
    w_sig_b   = w_neg_b ? -w_mag_b : w_mag_b;
    w_b_small = (w_eff_a >= w_eff_b);
  end

  logic [SIG_W-1:0] r_s1_big;
  logic [SIG_W-1:0] r_s1_small;
  logic [SIG_W-1:0] r_s1_small_mag;
  logic [EXP_W-1:0] r_s1_d;
  logic [EXP_W-1:0] r_s1_exp;
  logic             r_s1_b_small;

  // NOTE: the stage-1 payload carries no reset; r_s1_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (w_s1_adv) begin
      r_s1_b_small   <= w_b_small;
      r_s1_big       <= w_b_small ? w_sig_a : w_sig_b;
      r_s1_small     <= w_b_small ? w_sig_b : w_sig_a;
      r_s1_small_mag <= w_b_small ? w_mag_b : w_mag_a;
      r_s1_d         <= w_b_small ? (w_eff_a - w_eff_b) : (w_eff_b - w_eff_a);
      r_s1_exp       <= w_b_small ? w_eff_a : w_eff_b;
    end
  end

  // ---------------------------------------------------- stage 2: shift/sticky
  logic signed [OUT_W-1:0] w_small_lj;
  logic        [OUT_W-1:0] w_big_lj;
  logic        [OUT_W-1:0] w_mag_lj;
  logic        [OUT_W-1:0] w_shifted;
  logic                    w_sat;
  logic                    w_sticky;

  always_comb begin
    w_small_lj = {r_s1_small, {PAD_W{1'b0}}};
    w_big_lj   = {r_s1_big, {PAD_W{1'b0}}};
    w_mag_lj   = {r_s1_small_mag, {PAD_W{1'b0}}};
    w_sat      = (int'(r_s1_d) >= OUT_W);
    if (w_sat) w_shifted = {OUT_W{r_s1_small[SIG_W-1]}};
    else       w_shifted = w_small_lj >>> r_s1_d;
    // A shift of OUT_W or more clears the keep-mask, so every magnitude bit counts as lost.
    w_sticky   = |(w_mag_lj & ~(ONES << r_s1_d));
  end

  logic [OUT_W-1:0] r_out_a;
  logic [OUT_W-1:0] r_out_b;
  logic [EXP_W-1:0] r_out_exp;
  logic             r_out_sticky;

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_out_exp    <= '0;
      r_out_sticky <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_a      <= r_s1_b_small ? w_big_lj : w_shifted;
          r_out_b      <= r_s1_b_small ? w_shifted : w_big_lj;
          r_out_exp    <= r_s1_exp;
          r_out_sticky <= w_sticky;
        end
      end
    end
  end

  assign out_a      = r_out_a;
  assign out_b      = r_out_b;
  assign out_exp    = r_out_exp;
  assign out_sticky = r_out_sticky;

endmodule
